mem_bus_arbiter: RTL and testbench

Shares the single-port external memory (exmem) and the I/O space between two requesters: the CPU memory port (statemachine/dataPath) and the video fetch engine (read-only).
- Decodes CPU addresses into memory or I/O space, arbitrating round-robin on contention.
- Runs a fixed 3-state access sequence so both requesters see deterministic latency.
- Sits in top between the requesters and the memory/I/O devices.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_bus_arbiter_if.sv | 39 +++
 rtl/mem_bus_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory/I-O bus arbiter.
// Owner encoding doubles as the round-robin "last grant" marker.
package mem_bus_pkg;
    localparam int         ADDR_W_DEF    = 16;
    localparam int         DATA_W_DEF    = 16;
    localparam logic [1:0] IO_PREFIX_DEF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory and I/O signals of the arbiter grouped as one bundle.
// slave = arbiter view, master = requesters plus memory/I-O devices.
interface mem_bus_arbiter_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_adr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              io_sel;
    logic              io_we;
    logic [DATA_W-1:0] io_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, vid_req, vid_adr, mem_rdata, io_rdata,
        output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
        output mem_en, mem_we, mem_adr, mem_wdata, io_sel, io_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, vid_req, vid_adr, mem_rdata, io_rdata,
        input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
        input  mem_en, mem_we, mem_adr, mem_wdata, io_sel, io_we
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not served last wins.
module rr_arb2
    import mem_bus_pkg::*;
(
    input  logic   i_req_cpu,
    input  logic   i_req_vid,
    input  owner_e i_last_grant,
    output logic   o_valid,
    output owner_e o_owner
);
    always_comb begin
        o_valid = i_req_cpu | i_req_vid;
        o_owner = OWN_CPU;
        if (i_req_cpu && i_req_vid) begin
            o_owner = (i_last_grant == OWN_CPU) ? OWN_VID : OWN_CPU;
        end else if (i_req_vid) begin
            o_owner = OWN_VID;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port and the I/O space between the CPU and the video fetcher
// using a fixed IDLE -> ACCESS -> DONE sequence (strobe at +1, ack at +2).
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_W_DEF,
    parameter int         DATA_W    = DATA_W_DEF,
    parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEF
) (
    input logic             clk,
    input logic             rst,
    mem_bus_arbiter_if.slave bus
);
    state_e            r_state, w_state_next;
    owner_e            r_owner, w_owner_next, r_last_grant, w_last_next;
    logic              r_we, w_we_next;
    logic [ADDR_W-1:0] r_adr, w_adr_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next;
    logic              r_use_mem, w_use_mem_next, r_use_io, w_use_io_next;
    logic              r_mem_en, w_mem_en_next, r_mem_we, w_mem_we_next;
    logic              r_io_sel, w_io_sel_next, r_io_we, w_io_we_next;
    logic              r_cpu_ack, w_cpu_ack_next, r_vid_ack, w_vid_ack_next;
    logic [DATA_W-1:0] r_cpu_rdata, r_vid_rdata, w_rd_src;
    logic              w_gnt_valid, w_sel_we, w_sel_io;
    owner_e            w_gnt_owner;
    logic [ADDR_W-1:0] w_sel_adr;

    rr_arb2 u_rr_arb2 (
        .i_req_cpu    (bus.cpu_req),
        .i_req_vid    (bus.vid_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_gnt_valid),
        .o_owner      (w_gnt_owner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_owner_next   = r_owner;
        w_we_next      = r_we;
        w_adr_next     = r_adr;
        w_wdata_next   = r_wdata;
        w_use_mem_next = r_use_mem;
        w_use_io_next  = r_use_io;
        w_last_next    = r_last_grant;
        w_mem_en_next  = 1'b0;
        w_mem_we_next  = 1'b0;
        w_io_sel_next  = 1'b0;
        w_io_we_next   = 1'b0;
        w_cpu_ack_next = 1'b0;
        w_vid_ack_next = 1'b0;
        w_sel_adr      = (w_gnt_owner == OWN_CPU) ? bus.cpu_adr : bus.vid_adr;
        w_sel_we       = (w_gnt_owner == OWN_CPU) && bus.cpu_we;
        w_sel_io       = (w_sel_adr[ADDR_W-1 -: 2] == IO_PREFIX);
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_next   = ST_ACCESS;
                    w_owner_next   = w_gnt_owner;
                    w_we_next      = w_sel_we;
                    w_adr_next     = w_sel_adr;
                    w_wdata_next   = (w_gnt_owner == OWN_CPU) ? bus.cpu_wdata : '0;
                    // Video hitting I/O space gets neither strobe, only a zero-data ack.
                    w_use_io_next  = w_sel_io && (w_gnt_owner == OWN_CPU);
                    w_use_mem_next = !w_sel_io;
                    w_io_sel_next  = w_use_io_next;
                    w_io_we_next   = w_use_io_next && w_sel_we;
                    w_mem_en_next  = w_use_mem_next;
                    w_mem_we_next  = w_use_mem_next && w_sel_we;
                end
            end
            ST_ACCESS: begin
                w_state_next   = ST_DONE;
                w_cpu_ack_next = (r_owner == OWN_CPU);
                w_vid_ack_next = (r_owner == OWN_VID);
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_last_next  = r_owner;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Device read data arrives during DONE, so the ack cycle forwards it live.
    always_comb begin
        w_rd_src = '0;
        if (!r_we && r_use_io)       w_rd_src = bus.io_rdata;
        else if (!r_we && r_use_mem) w_rd_src = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_VID;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_wdata      <= '0;
            r_use_mem    <= 1'b0;
            r_use_io     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_io_sel     <= 1'b0;
            r_io_we      <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_vid_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vid_rdata  <= '0;
        end else begin
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_next;
            r_we         <= w_we_next;
            r_adr        <= w_adr_next;
            r_wdata      <= w_wdata_next;
            r_use_mem    <= w_use_mem_next;
            r_use_io     <= w_use_io_next;
            r_mem_en     <= w_mem_en_next;
            r_mem_we     <= w_mem_we_next;
            r_io_sel     <= w_io_sel_next;
            r_io_we      <= w_io_we_next;
            r_cpu_ack    <= w_cpu_ack_next;
            r_vid_ack    <= w_vid_ack_next;
            if (r_state == ST_DONE && r_owner == OWN_CPU) r_cpu_rdata <= w_rd_src;
            if (r_state == ST_DONE && r_owner == OWN_VID) r_vid_rdata <= w_rd_src;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_adr   = r_adr;
    assign bus.mem_wdata = r_wdata;
    assign bus.io_sel    = r_io_sel;
    assign bus.io_we     = r_io_we;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.vid_ack   = r_vid_ack;
    assign bus.cpu_rdata = r_cpu_ack ? w_rd_src : r_cpu_rdata;
    assign bus.vid_rdata = r_vid_ack ? w_rd_src : r_vid_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomised checks of the CPU/video memory bus arbiter.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bif ();

    mem_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Memory model: unwritten words return a fixed address pattern.
    logic [15:0] tb_mem [256];
    bit          tb_wv  [256];

    function automatic logic [15:0] pattern(input logic [15:0] a);
        return 16'hBEEF + (a - 16'h0010) * 16'h0111;
    endfunction

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return tb_wv[a[7:0]] ? tb_mem[a[7:0]] : pattern(a);
    endfunction

    initial begin
        bif.mem_rdata = 16'h0;
        bif.io_rdata  = 16'h0;
    end

    always @(posedge clk) begin
        if (bif.mem_en) begin
            if (bif.mem_we) begin
                tb_mem[bif.mem_adr[7:0]] <= bif.mem_wdata;
                tb_wv[bif.mem_adr[7:0]]  <= 1'b1;
            end else begin
                bif.mem_rdata <= mem_val(bif.mem_adr);
            end
        end
        if (bif.io_sel && !bif.io_we) bif.io_rdata <= {bif.mem_adr[7:0], 8'h5A};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic we, input logic [15:0] adr, input logic [15:0] wd);
        bif.cpu_req   = 1'b1;
        bif.cpu_we    = we;
        bif.cpu_adr   = adr;
        bif.cpu_wdata = wd;
    endtask

    // Random-phase requester state, index 0 = CPU, 1 = video.
    bit          pend [2];
    bit          cool [2];
    bit          rq_we [2];
    logic [15:0] rq_adr [2];
    int          lat [2];
    int          issued;
    int          acks;
    int          cycles;
    logic        ack;
    logic [15:0] rd, exp_rd;

    initial begin
        bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_adr = '0; bif.cpu_wdata = '0;
        bif.vid_req = 1'b0; bif.vid_adr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(bif.mem_en), 0);
        chk("rst_io_sel", 32'(bif.io_sel), 0);
        chk("rst_cpu_ack", 32'(bif.cpu_ack), 0);
        chk("rst_vid_ack", 32'(bif.vid_ack), 0);
        chk("rst_cpu_rdata", 32'(bif.cpu_rdata), 0);
        chk("rst_vid_rdata", 32'(bif.vid_rdata), 0);
        chk("rst_mem_adr", 32'(bif.mem_adr), 0);
        rst = 1'b1;
        tick();

        // CPU memory read
        cpu_drive(1'b0, 16'h0010, 16'h0);
        tick();
        chk("t1_mem_en", 32'(bif.mem_en), 1);
        chk("t1_mem_we", 32'(bif.mem_we), 0);
        chk("t1_io_sel", 32'(bif.io_sel), 0);
        chk("t1_mem_adr", 32'(bif.mem_adr), 32'h0010);
        bif.cpu_req = 1'b0;
        tick();
        chk("t1_cpu_ack", 32'(bif.cpu_ack), 1);
        chk("t1_cpu_rdata", 32'(bif.cpu_rdata), 32'hBEEF);
        chk("t1_vid_ack", 32'(bif.vid_ack), 0);
        chk("t1_strobe_off", 32'(bif.mem_en), 0);
        $display("txn cpu rd 0010 rdata=%04h", bif.cpu_rdata);
        tick();
        chk("t1_ack_1cyc", 32'(bif.cpu_ack), 0);
        chk("t1_rdata_hold", 32'(bif.cpu_rdata), 32'hBEEF);

        // CPU I/O write
        cpu_drive(1'b1, 16'hC004, 16'h1234);
        tick();
        chk("t2_io_sel", 32'(bif.io_sel), 1);
        chk("t2_io_we", 32'(bif.io_we), 1);
        chk("t2_mem_en", 32'(bif.mem_en), 0);
        chk("t2_adr", 32'(bif.mem_adr), 32'hC004);
        chk("t2_wdata", 32'(bif.mem_wdata), 32'h1234);
        bif.cpu_req = 1'b0;
        tick();
        chk("t2_cpu_ack", 32'(bif.cpu_ack), 1);
        chk("t2_cpu_rdata", 32'(bif.cpu_rdata), 0);
        chk("t2_io_off", 32'(bif.io_sel), 0);
        $display("txn cpu wr C004 data=1234");
        tick();

        // Contention from reset: CPU, video, CPU
        rst = 1'b0;
        cpu_drive(1'b0, 16'h0020, 16'h0);
        bif.vid_req = 1'b1;
        bif.vid_adr = 16'h0030;
        tick();
        rst = 1'b1;
        tick();
        chk("t3_n1_mem_en", 32'(bif.mem_en), 1);
        chk("t3_n1_adr", 32'(bif.mem_adr), 32'h0020);
        tick();
        chk("t3_n2_cpu_ack", 32'(bif.cpu_ack), 1);
        chk("t3_n2_cpu_rdata", 32'(bif.cpu_rdata), 32'hCFFF);
        chk("t3_n2_vid_ack", 32'(bif.vid_ack), 0);
        $display("txn cpu rd 0020 rdata=%04h", bif.cpu_rdata);
        tick();
        chk("t3_n3_mem_en", 32'(bif.mem_en), 0);
        tick();
        chk("t3_n4_mem_en", 32'(bif.mem_en), 1);
        chk("t3_n4_adr", 32'(bif.mem_adr), 32'h0030);
        tick();
        chk("t3_n5_vid_ack", 32'(bif.vid_ack), 1);
        chk("t3_n5_vid_rdata", 32'(bif.vid_rdata), 32'hE10F);
        chk("t3_n5_cpu_ack", 32'(bif.cpu_ack), 0);
        chk("t3_n5_cpu_hold", 32'(bif.cpu_rdata), 32'hCFFF);
        $display("txn vid rd 0030 rdata=%04h", bif.vid_rdata);
        tick();
        tick();
        chk("t3_n7_adr", 32'(bif.mem_adr), 32'h0020);
        chk("t3_n7_mem_en", 32'(bif.mem_en), 1);
        bif.cpu_req = 1'b0;
        bif.vid_req = 1'b0;
        tick();
        chk("t3_n8_cpu_ack", 32'(bif.cpu_ack), 1);
        $display("txn cpu rd 0020 rdata=%04h", bif.cpu_rdata);
        tick();

        // Video read in I/O space: no strobe, zero data
        bif.vid_req = 1'b1;
        bif.vid_adr = 16'hC100;
        tick();
        chk("t4_mem_en", 32'(bif.mem_en), 0);
        chk("t4_io_sel", 32'(bif.io_sel), 0);
        bif.vid_req = 1'b0;
        tick();
        chk("t4_vid_ack", 32'(bif.vid_ack), 1);
        chk("t4_vid_rdata", 32'(bif.vid_rdata), 0);
        chk("t4_io_sel_done", 32'(bif.io_sel), 0);
        $display("txn vid rd C100 rdata=%04h", bif.vid_rdata);
        tick();

        // Reset during ACCESS of a CPU write
        cpu_drive(1'b1, 16'h0040, 16'h5555);
        tick();
        chk("t5_mem_en", 32'(bif.mem_en), 1);
        chk("t5_mem_we", 32'(bif.mem_we), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_mem_en", 32'(bif.mem_en), 0);
        chk("t5_rst_mem_we", 32'(bif.mem_we), 0);
        chk("t5_rst_adr", 32'(bif.mem_adr), 0);
        chk("t5_rst_wdata", 32'(bif.mem_wdata), 0);
        bif.cpu_req = 1'b0;
        tick();
        chk("t5_no_ack", 32'(bif.cpu_ack), 0);
        chk("t5_no_strobe", 32'(bif.mem_en), 0);
        chk("t5_rdata_clr", 32'(bif.cpu_rdata), 0);
        rst = 1'b1;
        tick();
        chk("t5_idle_ack", 32'(bif.cpu_ack), 0);
        $display("txn cpu wr 0040 aborted by reset");
        cpu_drive(1'b0, 16'h0010, 16'h0);
        tick();
        chk("t5_rd_mem_en", 32'(bif.mem_en), 1);
        chk("t5_rd_adr", 32'(bif.mem_adr), 32'h0010);
        bif.cpu_req = 1'b0;
        tick();
        chk("t5_rd_ack", 32'(bif.cpu_ack), 1);
        chk("t5_rd_rdata", 32'(bif.cpu_rdata), 32'hBEEF);
        $display("txn cpu rd 0010 rdata=%04h", bif.cpu_rdata);
        tick();

        // Random mixed traffic
        issued = 0;
        acks   = 0;
        cycles = 0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; cool[r] = 1'b0; lat[r] = 0;
        end
        while ((issued < 1000 || pend[0] || pend[1]) && cycles < 20000) begin
            tick();
            cycles++;
            chk("excl_strobe", 32'(bif.mem_en & bif.io_sel), 0);
            for (int r = 0; r < 2; r++) begin
                ack = (r == 0) ? bif.cpu_ack : bif.vid_ack;
                rd  = (r == 0) ? bif.cpu_rdata : bif.vid_rdata;
                if (ack) begin
                    acks++;
                    chk("ack_pending", 32'(pend[r]), 1);
                    chk("wait_bound", 32'(lat[r] <= 4), 1);
                    if (rq_we[r])                      exp_rd = 16'h0;
                    else if (rq_adr[r][15:14] == 2'b11) exp_rd = (r == 0) ? {rq_adr[r][7:0], 8'h5A} : 16'h0;
                    else                               exp_rd = mem_val(rq_adr[r]);
                    chk("rand_rdata", 32'(rd), 32'(exp_rd));
                    $display("txn %s %s %04h rdata=%04h lat=%0d", (r == 0) ? "cpu" : "vid",
                             rq_we[r] ? "wr" : "rd", rq_adr[r], rd, lat[r]);
                    pend[r] = 1'b0;
                    cool[r] = 1'b1;
                    if (r == 0) bif.cpu_req = 1'b0;
                    else        bif.vid_req = 1'b0;
                end else if (pend[r]) begin
                    lat[r]++;
                end else if (cool[r]) begin
                    cool[r] = 1'b0;
                end else if (issued < 1000 && $urandom_range(0, 1) == 1) begin
                    rq_adr[r] = {($urandom_range(0, 3) == 0) ? 8'hC0 : 8'h00, 8'($urandom_range(0, 255))};
                    rq_we[r]  = (r == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    lat[r]    = 0;
                    pend[r]   = 1'b1;
                    issued++;
                    if (r == 0) cpu_drive(rq_we[r], rq_adr[r], 16'($urandom));
                    else begin
                        bif.vid_req = 1'b1;
                        bif.vid_adr = rq_adr[r];
                    end
                end
            end
        end
        chk("rand_drained", 32'(pend[0] | pend[1]), 0);
        chk("rand_issued", 32'(issued), 1000);
        chk("rand_acks", 32'(acks), 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
